mem_wb_stage: RTL and testbench

- Pipeline register and writeback selector between the memory-access stage and the register file.
- Captures the memory-access stage results each cycle and selects the writeback value: ALU result, load data, PC+4 or immediate.
- Drives the register-file write port; that same port is the forwarding source for earlier stages.
- Also tracks retired instructions and owns the sticky halt state of the core.

---
 rtl/mem_wb_stage_pkg.sv | 19 +
 rtl/mem_wb_stage_wb_mux.sv | 31 +++
 rtl/mem_wb_stage.sv | 108 ++++++++++
 tb/tb_mem_wb_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory-access/writeback boundary of the core:
// writeback-select codes, the retire FSM encoding and default widths.
package mem_wb_stage_pkg;

   localparam int XLEN_DEFAULT   = 32;
   localparam int REG_AW_DEFAULT = 5;
   localparam int RET_W_DEFAULT  = 32;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

endpackage

// File: rtl/mem_wb_stage_wb_mux.sv
// Combinational writeback selector: ALU result, load data, PC+4 or immediate.
module wb_mux
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [1:0]      sel,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] mem_data,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] pc_plus4;

   // The link address wraps naturally at the top of the address space.
   assign pc_plus4 = pc + XLEN'(4);

   always_comb begin
      wdata = alu_result;
      case (sel)
         WB_ALU:  wdata = alu_result;
         WB_MEM:  wdata = mem_data;
         WB_PC4:  wdata = pc_plus4;
         WB_IMM:  wdata = imm;
         default: wdata = alu_result;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with stored writeback value, register-file write
// port, retired-instruction counter and the sticky halt state of the core.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = REG_AW_DEFAULT,
   parameter int RET_W  = RET_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              m_valid,
   input  logic [XLEN-1:0]   m_PC,
   input  logic [XLEN-1:0]   m_imm32,
   input  logic [XLEN-1:0]   m_ALU_result,
   input  logic [XLEN-1:0]   m_DataWord,
   input  logic [REG_AW-1:0] m_Rd,
   input  logic              m_reg_wEn,
   input  logic [1:0]        m_wb_sel,
   input  logic              m_halt,
   output logic              rf_wEn,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              halted,
   output logic [RET_W-1:0]  retired_count
);

   state_t            state;
   logic              wb_valid;
   logic              wb_reg_wEn;
   logic              wb_halt;
   logic [REG_AW-1:0] wb_Rd;
   logic [XLEN-1:0]   wb_data;
   logic [XLEN-1:0]   sel_data;
   logic              retire;

   wb_mux #(
      .XLEN(XLEN)
   ) u_wb_mux (
      .sel        (m_wb_sel),
      .alu_result (m_ALU_result),
      .mem_data   (m_DataWord),
      .pc         (m_PC),
      .imm        (m_imm32),
      .wdata      (sel_data)
   );

   // The instruction in WB leaves the stage on any non-stalled edge while running.
   assign retire = wb_valid & ~stall & (state == RUN);

   // Pipeline register: halted state and flush both insert a bubble; payload is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid   <= 1'b0;
         wb_reg_wEn <= 1'b0;
         wb_halt    <= 1'b0;
         wb_Rd      <= '0;
         wb_data    <= '0;
      end else if (state == HALTED) begin
         wb_valid <= 1'b0;
      end else if (flush) begin
         wb_valid <= 1'b0;
      end else if (!stall) begin
         wb_valid   <= m_valid;
         wb_reg_wEn <= m_reg_wEn;
         wb_halt    <= m_halt;
         wb_Rd      <= m_Rd;
         wb_data    <= sel_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RUN;
         halted        <= 1'b0;
         retired_count <= '0;
      end else begin
         case (state)
            RUN: begin
               if (retire) begin
                  if (retired_count != {RET_W{1'b1}}) begin
                     retired_count <= retired_count + RET_W'(1);
                  end
                  if (wb_halt) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end
               end
            end
            HALTED: begin
               state  <= HALTED;
               halted <= 1'b1;
            end
            default: begin
               state  <= RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end

   assign rf_wEn   = wb_valid & wb_reg_wEn & (wb_Rd != '0) & (state == RUN);
   assign rf_waddr = wb_Rd;
   assign rf_wdata = wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a slot-level model,
// with a second instance using a 4-bit retire counter to exercise saturation.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        m_valid;
   logic [31:0] m_PC;
   logic [31:0] m_imm32;
   logic [31:0] m_ALU_result;
   logic [31:0] m_DataWord;
   logic [4:0]  m_Rd;
   logic        m_reg_wEn;
   logic [1:0]  m_wb_sel;
   logic        m_halt;

   logic        rf_wEn;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        halted;
   logic [31:0] retired_count;

   logic        rf_wEn4;
   logic [4:0]  rf_waddr4;
   logic [31:0] rf_wdata4;
   logic        halted4;
   logic [3:0]  retired_count4;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   mem_wb_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_PC(m_PC), .m_imm32(m_imm32),
      .m_ALU_result(m_ALU_result), .m_DataWord(m_DataWord), .m_Rd(m_Rd),
      .m_reg_wEn(m_reg_wEn), .m_wb_sel(m_wb_sel), .m_halt(m_halt),
      .rf_wEn(rf_wEn), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .halted(halted), .retired_count(retired_count)
   );

   mem_wb_stage #(.RET_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_PC(m_PC), .m_imm32(m_imm32),
      .m_ALU_result(m_ALU_result), .m_DataWord(m_DataWord), .m_Rd(m_Rd),
      .m_reg_wEn(m_reg_wEn), .m_wb_sel(m_wb_sel), .m_halt(m_halt),
      .rf_wEn(rf_wEn4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
      .halted(halted4), .retired_count(retired_count4)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Model state: the one instruction slot in WB plus core-level status.
   bit          s_valid, s_wen, s_halt, s_known;
   logic [4:0]  s_rd;
   logic [31:0] s_data;
   bit          mdl_halted;
   longint      mdl_count;
   int          mdl_count4;

   function automatic logic [31:0] wb_value(logic [1:0] sel, logic [31:0] pc,
                                            logic [31:0] imm, logic [31:0] alu,
                                            logic [31:0] dw);
      longint unsigned link;
      link = (longint'(pc) + 4) % 64'h1_0000_0000;
      case (sel)
         2'd0:    return alu;
         2'd1:    return dw;
         2'd2:    return link[31:0];
         default: return imm;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_valid = 0; s_wen = 0; s_halt = 0; s_known = 1;
         s_rd = 0; s_data = 0;
         mdl_halted = 0; mdl_count = 0; mdl_count4 = 0;
      end else if (mdl_halted) begin
         s_valid = 0;
      end else begin
         if (s_valid && !stall) begin
            if (mdl_count < 64'hFFFF_FFFF) mdl_count++;
            if (mdl_count4 < 15) mdl_count4++;
            if (s_halt) mdl_halted = 1;
         end
         if (flush) begin
            s_valid = 0;
            s_known = 0;
         end else if (!stall) begin
            s_valid = m_valid;
            s_wen   = m_reg_wEn;
            s_halt  = m_halt;
            s_rd    = m_Rd;
            s_data  = wb_value(m_wb_sel, m_PC, m_imm32, m_ALU_result, m_DataWord);
            s_known = 1;
         end
      end
   end

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("rf_wEn", 32'(rf_wEn),
                     32'(s_valid && s_wen && (s_rd != 0) && !mdl_halted));
         checkOutput("halted", 32'(halted), 32'(mdl_halted));
         checkOutput("retired_count", retired_count, mdl_count[31:0]);
         checkOutput("retired_count4", 32'(retired_count4), 32'(mdl_count4));
         checkOutput("halted4", 32'(halted4), 32'(mdl_halted));
         if (s_known) begin
            checkOutput("rf_waddr", 32'(rf_waddr), 32'(s_rd));
            checkOutput("rf_wdata", rf_wdata, s_data);
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [1:0] sel,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] alu, input logic [31:0] dw,
                                input logic [4:0] rd, input logic wen,
                                input logic hlt, input logic st, input logic fl);
      m_valid = v; m_wb_sel = sel; m_PC = pc; m_imm32 = imm;
      m_ALU_result = alu; m_DataWord = dw; m_Rd = rd; m_reg_wEn = wen;
      m_halt = hlt; stall = st; flush = fl;
      @(negedge clk);
   endtask

   task automatic applyRandom(input logic v, input logic hlt, input logic st, input logic fl);
      applyStimulus(v, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), hlt, st, fl);
   endtask

   task automatic applyBubble();
      applyStimulus(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic resetDut();
      #3 rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      logic [31:0] held;
      rst_n = 0;
      stall = 0; flush = 0; m_valid = 0; m_PC = 0; m_imm32 = 0;
      m_ALU_result = 0; m_DataWord = 0; m_Rd = 0; m_reg_wEn = 0;
      m_wb_sel = 0; m_halt = 0;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1;
      checkOutput("reset rf_wEn", 32'(rf_wEn), 0);
      checkOutput("reset rf_wdata", rf_wdata, 0);
      checkOutput("reset retired_count", retired_count, 0);
      rst_n = 1;

      $display("[TB] load path");
      applyStimulus(1, 2'b01, 32'h40, 0, 32'h1234, 32'hFFFFFF80, 5'd5, 1, 0, 0, 0);
      checkOutput("load rf_wEn", 32'(rf_wEn), 1);
      checkOutput("load rf_waddr", 32'(rf_waddr), 5);
      checkOutput("load rf_wdata", rf_wdata, 32'hFFFFFF80);
      checkOutput("load count before retire", retired_count, 0);
      applyBubble();
      checkOutput("load count after retire", retired_count, 1);

      $display("[TB] select and x0");
      applyStimulus(1, 2'b10, 32'h00000100, 0, 0, 0, 5'd7, 1, 0, 0, 0);
      checkOutput("pc4 rf_wdata", rf_wdata, 32'h00000104);
      applyStimulus(1, 2'b10, 32'hFFFFFFFC, 0, 0, 0, 5'd8, 1, 0, 0, 0);
      checkOutput("pc4 wrap rf_wdata", rf_wdata, 32'h00000000);
      applyStimulus(1, 2'b11, 0, 32'h12345000, 0, 0, 5'd9, 1, 0, 0, 0);
      checkOutput("imm rf_wdata", rf_wdata, 32'h12345000);
      applyStimulus(1, 2'b00, 0, 0, 32'h55, 0, 5'd0, 1, 0, 0, 0);
      checkOutput("x0 rf_wEn", 32'(rf_wEn), 0);
      applyBubble();
      checkOutput("x0 counted", retired_count, 5);

      $display("[TB] stall then flush");
      applyStimulus(1, 2'b00, 0, 0, 32'hA, 0, 5'd3, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyRandom(1, 0, 1, 0);
         checkOutput("stall rf_wdata", rf_wdata, 32'hA);
         checkOutput("stall rf_wEn", 32'(rf_wEn), 1);
         checkOutput("stall count", retired_count, 5);
      end
      applyRandom(1, 0, 1, 1);
      checkOutput("flush rf_wEn", 32'(rf_wEn), 0);
      applyBubble();
      checkOutput("flush not counted", retired_count, 5);

      $display("[TB] halt");
      resetDut();
      for (int i = 0; i < 4; i++) applyRandom(1, 0, 0, 0);
      applyStimulus(1, 2'b00, 0, 0, 0, 0, 5'd1, 1, 1, 0, 0);
      checkOutput("pre-halt halted", 32'(halted), 0);
      checkOutput("pre-halt count", retired_count, 4);
      applyBubble();
      checkOutput("halted", 32'(halted), 1);
      checkOutput("halt count", retired_count, 5);
      for (int i = 0; i < 10; i++) begin
         applyRandom(1, 0, 0, 0);
         checkOutput("halted rf_wEn", 32'(rf_wEn), 0);
      end
      checkOutput("halted count frozen", retired_count, 5);

      $display("[TB] async reset");
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      checkOutput("async halted", 32'(halted), 0);
      checkOutput("async count", retired_count, 0);
      checkOutput("async rf_wEn", 32'(rf_wEn), 0);
      @(negedge clk);
      rst_n = 1;
      applyStimulus(1, 2'b00, 0, 0, 32'h77, 0, 5'd4, 1, 0, 0, 0);
      checkOutput("post-reset rf_wdata", rf_wdata, 32'h77);
      applyBubble();
      checkOutput("post-reset count", retired_count, 1);

      $display("[TB] saturation");
      resetDut();
      for (int i = 0; i < 20; i++) applyRandom(1, 0, 0, 0);
      applyBubble();
      checkOutput("sat count4", 32'(retired_count4), 15);
      checkOutput("sat count32", retired_count, 20);

      $display("[TB] random traffic");
      resetDut();
      for (int i = 0; i < 400; i++) begin
         if (i % 100 == 99) begin
            resetDut();
         end else begin
            applyRandom(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0),
                        1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
         end
      end
      held = 0;
      chk_en = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
